alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//  Execute-stage datapath for the single-cycle MIPS CPU. Merges three functions:
//  - ALU-control decode: ALUOp + funct -> 4-bit alu_ctl.
//  - 32-bit MIPS ALU.
//  - PC adders: pc+4 and the branch target.
//  Sits between instruction decode/regfile and data memory. All outputs are registered.
// PARAMETERS
//  WIDTH  32  datapath width; all arithmetic and flag rules below assume 32
// PORTS
//  clk           in   1   single clock; all state updates on rising edge
//  reset         in   1   synchronous, active-high; clears all output registers
//  alu_op        in   2   ALUOp from main control
//  funct         in   6   instr[5:0]
//  a             in   32  ALU operand A (ReadData1)
//  b             in   32  ALU operand B (ReadData2 or imm32, muxed outside)
//  cin           in   1   carry-in, used by ADD only
//  pc            in   32  current instruction address
//  imm32         in   32  sign-extended immediate
//  alu_ctl       out  4   decoded ALU operation (registered)
//  alu_res       out  32  ALU result
//  zero          out  1   alu_res == 0
//  ovf           out  1   signed overflow (ADD/SUB only)
//  cout          out  1   carry out of bit 31 (ADD/SUB only)
//  alu_illegal   out  1   alu_op=10 with an unsupported funct
//  pc_plus4      out  32  pc + 4
//  branch_target out  32  pc + 4 + (imm32 << 2)
// BEHAVIOUR
//  Timing:
//  - Combinational core feeds output registers; latency is exactly 1 cycle.
//  - Inputs are sampled at rising edge N; results are visible after edge N.
//  - No enable: every cycle updates.
//  Reset:
//  - reset high at an edge sets every output to 0, including zero.
//  - reset has priority over new data; mid-operation reset discards the pending result.
//  alu_ctl encoding:
//  - 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0110 SUB, 0111 SLT, 1100 NOR.
//  Decode:
//  - alu_op 00 -> ADD (lw/sw/addi).
//  - alu_op 01 -> SUB (beq/bne).
//  - alu_op 11 -> SLT (slti).
//  - alu_op 10 -> by funct:
//      100000 ADD, 100001 ADD, 100010 SUB, 100011 SUB, 100100 AND,
//      100101 OR, 100110 XOR, 100111 NOR, 101010 SLT.
//    Any other funct -> ADD with alu_illegal=1.
//  - alu_illegal is 0 in all other cases.
//  Operations:
//  - ADD: {cout,res} = a + b + cin.
//  - SUB: {cout,res} = a + ~b + 1; cin is ignored; cout=1 means no borrow.
//  - ovf = (sign(a')==sign(b')) && (sign(res)!=sign(a')), where b' = b for ADD and ~b for SUB.
//  - SLT: signed a<b, computed correctly even when a-b overflows; res = {31'b0, lt}.
//    ovf=0 and cout=0 for SLT.
//  - AND/OR/XOR/NOR: bitwise; ovf=0, cout=0.
//  - zero is computed from the final result for every operation.
//  PC adders:
//  - Pure modulo-2^32 addition with no flags; wrap-around is silent (0xFFFFFFFC+4 -> 0).
//  - imm32<<2 discards bits 31:30 of imm32.
//  - Both PC adders run every cycle, independent of alu_op.
// TESTING
//  1. reset=1 for one edge with nonzero inputs -> all outputs 0; deassert -> data appears 1 cycle later.
//  2. alu_op=10, funct=100000, a=0x7FFFFFFF, b=1, cin=0 -> res=0x80000000, ovf=1, cout=0, zero=0, alu_ctl=0010.
//  3. alu_op=01, a=5, b=5 -> res=0, zero=1, cout=1, ovf=0, alu_ctl=0110.
//  4. SLT cases:
//     - funct=101010, a=0x80000000, b=1 -> res=1.
//     - a=1, b=0x80000000 -> res=0.
//     - a=0x7FFFFFFF, b=0xFFFFFFFF -> res=0.
//  5. funct=100111, a=0, b=0 -> res=0xFFFFFFFF.
//     funct=000000 -> ADD, alu_illegal=1.
//     alu_op=00, cin=1, a=b=0xFFFFFFFF -> res=0xFFFFFFFF, cout=1.
//  6. PC adders:
//     - pc=0x00400000, imm32=0xFFFFFFFF -> pc_plus4=0x00400004, branch_target=0x00400000.
//     - pc=0xFFFFFFFC -> pc_plus4=0.

Source files
------------

// File: rtl/alu_exec_unit.sv
// Execute stage for the single-cycle MIPS core: ALU-control decode, 32-bit ALU and PC adders.
// Every output is registered, so results appear one cycle after their inputs are sampled.
module alu_exec_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] imm32,
    output logic [3:0]       alu_ctl,
    output logic [WIDTH-1:0] alu_res,
    output logic             zero,
    output logic             ovf,
    output logic             cout,
    output logic             alu_illegal,
    output logic [WIDTH-1:0] pc_plus4,
    output logic [WIDTH-1:0] branch_target
);

    localparam logic [3:0] CtlAnd = 4'b0000;
    localparam logic [3:0] CtlOr  = 4'b0001;
    localparam logic [3:0] CtlAdd = 4'b0010;
    localparam logic [3:0] CtlXor = 4'b0011;
    localparam logic [3:0] CtlSub = 4'b0110;
    localparam logic [3:0] CtlSlt = 4'b0111;
    localparam logic [3:0] CtlNor = 4'b1100;

    logic [3:0]       ctl_d;
    logic             illegal_d;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sub_sum;
    logic             add_ovf;
    logic             sub_ovf;
    logic             lt;
    logic [WIDTH-1:0] res_d;
    logic             ovf_d;
    logic             cout_d;
    logic [WIDTH-1:0] pc_plus4_d;
    logic [WIDTH-1:0] branch_target_d;

    always_comb begin
        ctl_d     = CtlAdd;
        illegal_d = 1'b0;
        unique case (alu_op)
            2'b00: ctl_d = CtlAdd;
            2'b01: ctl_d = CtlSub;
            2'b11: ctl_d = CtlSlt;
            2'b10: begin
                case (funct)
                    6'b100000, 6'b100001: ctl_d = CtlAdd;
                    6'b100010, 6'b100011: ctl_d = CtlSub;
                    6'b100100:            ctl_d = CtlAnd;
                    6'b100101:            ctl_d = CtlOr;
                    6'b100110:            ctl_d = CtlXor;
                    6'b100111:            ctl_d = CtlNor;
                    6'b101010:            ctl_d = CtlSlt;
                    default: begin
                        ctl_d     = CtlAdd;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            default: ctl_d = CtlAdd;
        endcase
    end

    assign add_sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    assign sub_sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (add_sum[WIDTH-1] != a[WIDTH-1]);
    assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (sub_sum[WIDTH-1] != a[WIDTH-1]);
    // On differing signs the negative operand is smaller, which sidesteps subtraction overflow.
    assign lt = (a[WIDTH-1] != b[WIDTH-1]) ? a[WIDTH-1] : sub_sum[WIDTH-1];

    always_comb begin
        res_d  = add_sum[WIDTH-1:0];
        ovf_d  = 1'b0;
        cout_d = 1'b0;
        unique case (ctl_d)
            CtlAdd: begin
                res_d  = add_sum[WIDTH-1:0];
                ovf_d  = add_ovf;
                cout_d = add_sum[WIDTH];
            end
            CtlSub: begin
                res_d  = sub_sum[WIDTH-1:0];
                ovf_d  = sub_ovf;
                cout_d = sub_sum[WIDTH];
            end
            CtlSlt: res_d = {{(WIDTH-1){1'b0}}, lt};
            CtlAnd: res_d = a & b;
            CtlOr:  res_d = a | b;
            CtlXor: res_d = a ^ b;
            CtlNor: res_d = ~(a | b);
            default: res_d = add_sum[WIDTH-1:0];
        endcase
    end

    assign pc_plus4_d      = pc + WIDTH'(4);
    assign branch_target_d = pc_plus4_d + {imm32[WIDTH-3:0], 2'b00};

    always_ff @(posedge clk) begin
        if (reset) begin
            alu_ctl       <= 4'b0000;
            alu_res       <= '0;
            zero          <= 1'b0;
            ovf           <= 1'b0;
            cout          <= 1'b0;
            alu_illegal   <= 1'b0;
            pc_plus4      <= '0;
            branch_target <= '0;
        end else begin
            alu_ctl       <= ctl_d;
            alu_res       <= res_d;
            zero          <= (res_d == '0);
            ovf           <= ovf_d;
            cout          <= cout_d;
            alu_illegal   <= illegal_d;
            pc_plus4      <= pc_plus4_d;
            branch_target <= branch_target_d;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit with hand-computed expectations.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] pc;
    logic [31:0] imm32;
    logic [3:0]  alu_ctl;
    logic [31:0] alu_res;
    logic        zero;
    logic        ovf;
    logic        cout;
    logic        alu_illegal;
    logic [31:0] pc_plus4;
    logic [31:0] branch_target;

    int total = 0;
    int bad   = 0;

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .alu_op       (alu_op),
        .funct        (funct),
        .a            (a),
        .b            (b),
        .cin          (cin),
        .pc           (pc),
        .imm32        (imm32),
        .alu_ctl      (alu_ctl),
        .alu_res      (alu_res),
        .zero         (zero),
        .ovf          (ovf),
        .cout         (cout),
        .alu_illegal  (alu_illegal),
        .pc_plus4     (pc_plus4),
        .branch_target(branch_target)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] va,
                        input logic [31:0] vb, input logic ci);
        alu_op = op;
        funct  = fn;
        a      = va;
        b      = vb;
        cin    = ci;
        @(posedge clk);
        #1;
    endtask

    // Checks ctl, res, zero, ovf, cout and illegal after a step.
    task automatic chk_alu(input string tag, input logic [3:0] e_ctl, input logic [31:0] e_res,
                           input logic e_zero, input logic e_ovf, input logic e_cout,
                           input logic e_ill);
        chk({tag, ".ctl"},  {28'd0, alu_ctl},     {28'd0, e_ctl});
        chk({tag, ".res"},  alu_res,              e_res);
        chk({tag, ".zero"}, {31'd0, zero},        {31'd0, e_zero});
        chk({tag, ".ovf"},  {31'd0, ovf},         {31'd0, e_ovf});
        chk({tag, ".cout"}, {31'd0, cout},        {31'd0, e_cout});
        chk({tag, ".ill"},  {31'd0, alu_illegal}, {31'd0, e_ill});
    endtask

    initial begin
        reset = 1'b1;
        pc    = 32'h0000_0100;
        imm32 = 32'h0000_0001;
        step(2'b10, 6'b100000, 32'd3, 32'd4, 1'b1);
        chk_alu("rst", 4'b0000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst.pc4", pc_plus4, 32'h0);
        chk("rst.bt", branch_target, 32'h0);

        reset = 1'b0;
        step(2'b10, 6'b100000, 32'd3, 32'd4, 1'b0);
        chk_alu("first", 4'b0010, 32'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("first.pc4", pc_plus4, 32'h0000_0104);
        chk("first.bt", branch_target, 32'h0000_0108);

        step(2'b10, 6'b100000, 32'h7FFF_FFFF, 32'd1, 1'b0);
        chk_alu("add_ovf", 4'b0010, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0);

        step(2'b01, 6'b000000, 32'd5, 32'd5, 1'b1);
        chk_alu("beq", 4'b0110, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);

        step(2'b10, 6'b100010, 32'd3, 32'd5, 1'b0);
        chk_alu("sub_borrow", 4'b0110, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b0);

        step(2'b10, 6'b100011, 32'h8000_0000, 32'd1, 1'b0);
        chk_alu("sub_ovf", 4'b0110, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1, 1'b0);

        step(2'b10, 6'b101010, 32'h8000_0000, 32'd1, 1'b0);
        chk_alu("slt1", 4'b0111, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(2'b10, 6'b101010, 32'd1, 32'h8000_0000, 1'b0);
        chk_alu("slt2", 4'b0111, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(2'b10, 6'b101010, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        chk_alu("slt3", 4'b0111, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(2'b11, 6'b000000, 32'hFFFF_FFFB, 32'd3, 1'b1);
        chk_alu("slti", 4'b0111, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0);

        step(2'b10, 6'b100111, 32'h0, 32'h0, 1'b0);
        chk_alu("nor", 4'b1100, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0);
        step(2'b10, 6'b100100, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0);
        chk_alu("and", 4'b0000, 32'hF000_F000, 1'b0, 1'b0, 1'b0, 1'b0);
        step(2'b10, 6'b100101, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0);
        chk_alu("or", 4'b0001, 32'hFFF0_FFF0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(2'b10, 6'b100110, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0);
        chk_alu("xor", 4'b0011, 32'h0FF0_0FF0, 1'b0, 1'b0, 1'b0, 1'b0);

        step(2'b10, 6'b000000, 32'd2, 32'd3, 1'b0);
        chk_alu("illegal", 4'b0010, 32'd5, 1'b0, 1'b0, 1'b0, 1'b1);

        step(2'b00, 6'b101010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        chk_alu("lw_cin", 4'b0010, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0);

        pc    = 32'h0040_0000;
        imm32 = 32'hFFFF_FFFF;
        step(2'b00, 6'b000000, 32'd0, 32'd0, 1'b0);
        chk_alu("add_zero", 4'b0010, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("pc.pc4", pc_plus4, 32'h0040_0004);
        chk("pc.bt", branch_target, 32'h0040_0000);

        pc    = 32'hFFFF_FFFC;
        imm32 = 32'hC000_0001;
        step(2'b01, 6'b000000, 32'd1, 32'd2, 1'b0);
        chk("wrap.pc4", pc_plus4, 32'h0000_0000);
        chk("wrap.bt", branch_target, 32'h0000_0004);

        // Reset mid-stream discards the result computed from these inputs.
        reset = 1'b1;
        step(2'b10, 6'b100010, 32'h8000_0000, 32'd1, 1'b0);
        chk_alu("rst2", 4'b0000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst2.pc4", pc_plus4, 32'h0);
        chk("rst2.bt", branch_target, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
